ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter RAM_ADDRESS_BITWIDTH, default 16: word-address width of the attached byte-enabled RAM.
REQ-002 Parameter DATA_BITWIDTH, default 32, fixed: RAM word width; 4 byte lanes of 8 bits.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  client request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 req_sign_ext  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-010 req_address  input  RAM_ADDRESS_BITWIDTH+2  byte address.
REQ-011 req_data  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse for loads and stores.
REQ-013 resp_data  output  32  load result; 0 for stores.
REQ-014 ram_address  output  RAM_ADDRESS_BITWIDTH  word address to RAM.
REQ-015 ram_write_enable  output  4  per-lane write enable to RAM.
REQ-016 ram_data_out  output  32  write data to RAM data input.
REQ-017 ram_data_in  input  32  RAM read data, combinational from ram_address.

Function
REQ-018 States: IDLE, FIRST, SECOND; req_ready = 1 only in IDLE.
REQ-019 Accept when req_valid && req_ready; latch all req_* fields; go to FIRST.
REQ-020 Lanes: offset = address[1:0]; bytes n = 1/2/4; span when offset+n > 4.
REQ-021 FIRST: ram_address = latched address[MSB:2]; lanes offset..min(3,offset+n-1) active.
REQ-022 SECOND, entered from FIRST only on span: ram_address = first word address + 1, wrapping modulo 2^RAM_ADDRESS_BITWIDTH; lanes 0..offset+n-5 active.
REQ-023 Stores: ram_data_out = low/high 32 bits of ({32'b0,req_data} << 8*offset) in FIRST/SECOND; ram_write_enable = active lanes; 0 in IDLE and for loads.
REQ-024 Loads: in FIRST capture ram_data_in; in SECOND capture ram_data_in; result = ({second,first} >> 8*offset), masked to n bytes, then sign- or zero-extended per req_sign_ext.
REQ-025 Final access state transitions to IDLE and registers resp_valid = 1 for exactly one cycle together with resp_data.
REQ-026 Latency: accept at cycle T; non-spanning resp_valid at T+2; spanning resp_valid at T+3.
REQ-027 A request is accepted in the same cycle resp_valid of the previous one is high; no bubble beyond REQ-026.
REQ-028 ram_address = 0 and ram_data_out = 0 in IDLE.

Reset
REQ-029 rst_n low: state IDLE, resp_valid 0, resp_data 0, latched request cleared, ram_write_enable 0 immediately (asynchronous).
REQ-030 Reset mid-access aborts: no further RAM writes, no resp_valid for the aborted request; a completed FIRST write remains.

Structure
REQ-031 Shared package ram_access_pkg: size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and state encodings.
REQ-032 One combinational sub-module ram_lane_align: computes lane masks, write shift and read extract/extend from offset, size, sign flag.

Verification (RAM init word0 = 0x44332211, word1 = 0x88776655; RAM_ADDRESS_BITWIDTH 16)
REQ-033 Signed byte load addr 0x3 -> resp_data 0x00000044 at T+2; signed byte load addr 0x7 -> 0xFFFFFF88.
REQ-034 Word load addr 0x2 -> ram_address 0 then 1, resp_data 0x66554433 at T+3.
REQ-035 Half store 0xBEEF addr 0x3 -> enables 1000 then 0001; word0 = 0xEF332211, word1 = 0x887766BE.
REQ-036 Word load addr 0x3FFFE -> ram_address 0xFFFF then 0x0000; result combines top two bytes of word 0xFFFF with bytes 0..1 of word 0.
REQ-037 rst_n low during SECOND of the REQ-035 store -> enables 0 at once, word1 unchanged, no resp_valid, req_ready 1 after release.
REQ-038 req_valid held for two loads -> second accepted in the resp_valid cycle of the first; resp_valid pulses separated by exactly 2 cycles.

Source files
------------

// File: rtl/ram_access_pkg.sv
// Shared encodings for the byte-enabled RAM access controller:
// request size codes and controller state encodings.
`default_nettype none

package ram_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_access_ctrl_if.sv
// Client request/response bus of the RAM access controller.
`default_nettype none

interface ram_access_ctrl_if #(
    parameter int RAM_ADDRESS_BITWIDTH = 16
);
    logic                            req_valid;
    logic                            req_ready;
    logic                            req_write;
    logic [1:0]                      req_size;
    logic                            req_sign_ext;
    logic [RAM_ADDRESS_BITWIDTH+1:0] req_address;
    logic [31:0]                     req_data;
    logic                            resp_valid;
    logic [31:0]                     resp_data;

    modport master (
        output req_valid, req_write, req_size, req_sign_ext, req_address, req_data,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_sign_ext, req_address, req_data,
        output req_ready, resp_valid, resp_data
    );
endinterface

`default_nettype wire

// File: rtl/ram_lane_align.sv
// Combinational lane logic: byte-lane masks for both words, store data
// shift across the word pair, and load extract with sign/zero extension.
`default_nettype none

module ram_lane_align
    import ram_access_pkg::*;
(
    input  wire logic [1:0]  offset,
    input  wire logic [1:0]  size,
    input  wire logic        sign_ext,
    input  wire logic [31:0] wdata,
    input  wire logic [63:0] rdata,
    output logic             span,
    output logic [3:0]       first_mask,
    output logic [3:0]       second_mask,
    output logic [31:0]      wdata_lo,
    output logic [31:0]      wdata_hi,
    output logic [31:0]      rdata_ext
);

    logic [3:0]  size_mask;
    logic [7:0]  lane_bits;
    logic [4:0]  shamt;
    logic [63:0] wshift;
    logic [31:0] rsel;

    always_comb begin
        case (size)
            SIZE_BYTE: size_mask = 4'b0001;
            SIZE_HALF: size_mask = 4'b0011;
            default:   size_mask = 4'b1111;
        endcase

        // Lanes that fall off the top of the first word land in the second word
        lane_bits   = {4'b0000, size_mask} << offset;
        first_mask  = lane_bits[3:0];
        second_mask = lane_bits[7:4];
        span        = |lane_bits[7:4];

        shamt    = {offset, 3'b000};
        wshift   = {32'b0, wdata} << shamt;
        wdata_lo = wshift[31:0];
        wdata_hi = wshift[63:32];

        rsel = 32'(rdata >> shamt);
        case (size)
            SIZE_BYTE: rdata_ext = {{24{sign_ext & rsel[7]}}, rsel[7:0]};
            SIZE_HALF: rdata_ext = {{16{sign_ext & rsel[15]}}, rsel[15:0]};
            default:   rdata_ext = rsel;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ram_access_ctrl.sv
// Byte/half/word load-store controller for a word-wide byte-enabled RAM;
// unaligned accesses crossing a word boundary take two RAM cycles.
`default_nettype none

module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int RAM_ADDRESS_BITWIDTH = 16,
    parameter int DATA_BITWIDTH        = 32
)(
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    ram_access_ctrl_if.slave                     bus,
    output logic [RAM_ADDRESS_BITWIDTH-1:0]      ram_address,
    output logic [LANES-1:0]                     ram_write_enable,
    output logic [DATA_BITWIDTH-1:0]             ram_data_out,
    input  wire logic [DATA_BITWIDTH-1:0]        ram_data_in
);

    state_t                          state;
    state_t                          state_next;
    logic                            lat_write;
    logic [1:0]                      lat_size;
    logic                            lat_sign;
    logic [RAM_ADDRESS_BITWIDTH+1:0] lat_addr;
    logic [31:0]                     lat_data;
    logic [31:0]                     first_word;
    logic                            resp_valid_reg;
    logic [31:0]                     resp_data_reg;

    logic [RAM_ADDRESS_BITWIDTH-1:0] word_addr;
    logic [63:0]                     read_window;
    logic                            span;
    logic [3:0]                      first_mask;
    logic [3:0]                      second_mask;
    logic [31:0]                     wdata_lo;
    logic [31:0]                     wdata_hi;
    logic [31:0]                     rdata_ext;

    assign word_addr      = lat_addr[RAM_ADDRESS_BITWIDTH+1:2];
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;

    // Second-word load data is combined with the word captured in FIRST
    assign read_window = (state == ST_SECOND) ? {ram_data_in, first_word}
                                              : {32'b0, ram_data_in};

    ram_lane_align u_align (
        .offset      (lat_addr[1:0]),
        .size        (lat_size),
        .sign_ext    (lat_sign),
        .wdata       (lat_data),
        .rdata       (read_window),
        .span        (span),
        .first_mask  (first_mask),
        .second_mask (second_mask),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next       = state;
        ram_address      = '0;
        ram_write_enable = '0;
        ram_data_out     = '0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) state_next = ST_FIRST;
            end
            ST_FIRST: begin
                state_next  = span ? ST_SECOND : ST_IDLE;
                ram_address = word_addr;
                if (lat_write) begin
                    ram_write_enable = first_mask;
                    ram_data_out     = wdata_lo;
                end
            end
            ST_SECOND: begin
                state_next  = ST_IDLE;
                ram_address = word_addr + {{(RAM_ADDRESS_BITWIDTH-1){1'b0}}, 1'b1};
                if (lat_write) begin
                    ram_write_enable = second_mask;
                    ram_data_out     = wdata_hi;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write      <= 1'b0;
            lat_size       <= '0;
            lat_sign       <= 1'b0;
            lat_addr       <= '0;
            lat_data       <= '0;
            first_word     <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_write <= bus.req_write;
                        lat_size  <= bus.req_size;
                        lat_sign  <= bus.req_sign_ext;
                        lat_addr  <= bus.req_address;
                        lat_data  <= bus.req_data;
                    end
                end
                ST_FIRST: begin
                    first_word <= ram_data_in;
                    if (!span) begin
                        resp_valid_reg <= 1'b1;
                        resp_data_reg  <= lat_write ? 32'b0 : rdata_ext;
                    end
                end
                ST_SECOND: begin
                    resp_valid_reg <= 1'b1;
                    resp_data_reg  <= lat_write ? 32'b0 : rdata_ext;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a byte-enabled RAM model.
`default_nettype none

module tb_ram_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] ram_address;
    logic [3:0]  ram_write_enable;
    logic [31:0] ram_data_out;
    logic [31:0] ram_data_in;
    logic [31:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    ram_access_ctrl_if #(.RAM_ADDRESS_BITWIDTH(16)) bus ();

    ram_access_ctrl #(.RAM_ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .ram_address      (ram_address),
        .ram_write_enable (ram_write_enable),
        .ram_data_out     (ram_data_out),
        .ram_data_in      (ram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ram_data_in = mem[ram_address];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_write_enable[i]) mem[ram_address][8*i +: 8] = ram_data_out[8*i +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid with data %h expected none", bus.resp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_data", bus.resp_data, e.data);
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [17:0] addr, input logic [31:0] data,
                         input logic [31:0] exp, input bit spans, input bit want_resp,
                         output int acc);
        int waited;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_sign_ext = sx;
        bus.req_address  = addr;
        bus.req_data     = data;
        bus.req_valid    = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 within 20 cycles");
        end
        acc = cyc;
        if (want_resp) sb.push_back('{exp, cyc + (spans ? 3 : 2)});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int acc1, acc2;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_sign_ext = 1'b0;
        bus.req_address  = '0;
        bus.req_data     = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[0]      = 32'h44332211;
        mem[1]      = 32'h88776655;
        mem[4]      = 32'h00000000;
        mem[5]      = 32'hCAFEF00D;
        mem[16'hFFFF] = 32'hDDCCBBAA;

        #3;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rst_resp_data", bus.resp_data, 32'h0);
        check("rst_write_enable", {28'b0, ram_write_enable}, 32'h0);
        check("rst_ram_address", {16'b0, ram_address}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed byte loads
        issue(1'b0, 2'b00, 1'b1, 18'h00003, 32'h0, 32'h00000044, 1'b0, 1'b1, acc1);
        drain();
        issue(1'b0, 2'b00, 1'b1, 18'h00007, 32'h0, 32'hFFFFFF88, 1'b0, 1'b1, acc1);
        drain();

        // Spanning word load
        issue(1'b0, 2'b10, 1'b0, 18'h00002, 32'h0, 32'h66554433, 1'b1, 1'b1, acc1);
        bus.req_valid = 1'b0;
        check("span_load_addr_first", {16'b0, ram_address}, 32'h0);
        @(negedge clk);
        check("span_load_addr_second", {16'b0, ram_address}, 32'h1);
        drain();

        // Spanning half store
        issue(1'b1, 2'b01, 1'b0, 18'h00003, 32'h0000BEEF, 32'h0, 1'b1, 1'b1, acc1);
        bus.req_valid = 1'b0;
        check("store_we_first", {28'b0, ram_write_enable}, 32'h8);
        @(negedge clk);
        check("store_we_second", {28'b0, ram_write_enable}, 32'h1);
        drain();
        check("store_word0", mem[0], 32'hEF332211);
        check("store_word1", mem[1], 32'h887766BE);

        // Word load wrapping at the top of the address space
        issue(1'b0, 2'b10, 1'b0, 18'h3FFFE, 32'h0, 32'h2211DDCC, 1'b1, 1'b1, acc1);
        bus.req_valid = 1'b0;
        check("wrap_addr_first", {16'b0, ram_address}, 32'h0000FFFF);
        @(negedge clk);
        check("wrap_addr_second", {16'b0, ram_address}, 32'h0);
        drain();

        // Half loads, unsigned and signed
        issue(1'b0, 2'b01, 1'b0, 18'h00005, 32'h0, 32'h00007766, 1'b0, 1'b1, acc1);
        drain();
        issue(1'b0, 2'b01, 1'b1, 18'h00006, 32'h0, 32'hFFFF8877, 1'b0, 1'b1, acc1);
        drain();

        // Byte store, aligned word store, size 11 load
        issue(1'b1, 2'b00, 1'b0, 18'h00001, 32'h0000005A, 32'h0, 1'b0, 1'b1, acc1);
        drain();
        check("byte_store_word0", mem[0], 32'hEF335A11);
        issue(1'b1, 2'b10, 1'b0, 18'h00008, 32'h12345678, 32'h0, 1'b0, 1'b1, acc1);
        drain();
        check("word_store_word2", mem[2], 32'h12345678);
        issue(1'b0, 2'b11, 1'b0, 18'h00008, 32'h0, 32'h12345678, 1'b0, 1'b1, acc1);
        drain();

        // Reset during the second write of a spanning store
        issue(1'b1, 2'b01, 1'b0, 18'h00013, 32'h0000BEEF, 32'h0, 1'b1, 1'b0, acc1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_we_second", {28'b0, ram_write_enable}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_we_reset", {28'b0, ram_write_enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", {31'b0, bus.req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        check("abort_word4", mem[4], 32'hEF000000);
        check("abort_word5", mem[5], 32'hCAFEF00D);

        // Back-to-back loads with req_valid held
        issue(1'b0, 2'b00, 1'b0, 18'h00000, 32'h0, 32'h00000011, 1'b0, 1'b1, acc1);
        issue(1'b0, 2'b00, 1'b1, 18'h00007, 32'h0, 32'hFFFFFF88, 1'b0, 1'b1, acc2);
        bus.req_valid = 1'b0;
        check("b2b_accept_gap", 32'(acc2 - acc1), 32'h2);
        repeat (5) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
